// File: rtl/dffa_univ.sv
// Universal register: parallel load, sync clear, shift/rotate, up/down count, terminal-count and sticky wrap flag.
// Latency: one clk from any control to qa/ovf; no backpressure, every edge is accepted.
module dffa_univ #(
    parameter int              WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             sclr,
    input  logic             load,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] da,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] qa,
    output logic             so_l,
    output logic             so_r,
    output logic             tc,
    output logic             ovf
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_ROL  = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_UP   = 3'b101;
    localparam logic [2:0] M_DN   = 3'b110;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] qa_nxt;
    logic             ovf_nxt;

    assign so_l = qa[WIDTH-1];
    assign so_r = qa[0];

    // tc is qualified by mode only, so it can be observed before en is raised
    always_comb begin
        tc = 1'b0;
        case (mode)
            M_UP:    tc = &qa;
            M_DN:    tc = ~|qa;
            default: tc = 1'b0;
        endcase
    end

    always_comb begin
        qa_nxt  = qa;
        ovf_nxt = ovf;
        if (sclr) begin
            qa_nxt  = RST_VAL;
            ovf_nxt = 1'b0;
        end else if (load) begin
            qa_nxt  = da;
            ovf_nxt = 1'b0;
        end else if (en) begin
            case (mode)
                M_HOLD: qa_nxt = qa;
                M_SHL:  qa_nxt = {qa[WIDTH-2:0], sin_r};
                M_SHR:  qa_nxt = {sin_l, qa[WIDTH-1:1]};
                M_ROL:  qa_nxt = {qa[WIDTH-2:0], qa[WIDTH-1]};
                M_ROR:  qa_nxt = {qa[0], qa[WIDTH-1:1]};
                M_UP: begin
                    qa_nxt = qa + ONE;
                    if (tc) ovf_nxt = 1'b1;
                end
                M_DN: begin
                    qa_nxt = qa - ONE;
                    if (tc) ovf_nxt = 1'b1;
                end
                default: qa_nxt = qa;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            qa  <= RST_VAL;
            ovf <= 1'b0;
        end else begin
            qa  <= qa_nxt;
            ovf <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_dffa_univ.sv
// Bench for dffa_univ (WIDTH=4): directed scenarios plus randomized run against an arithmetic reference model.
module tb_dffa_univ;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       sclr, load, en, sin_r, sin_l;
    logic [2:0] mode;
    logic [3:0] da;
    logic [3:0] qa;
    logic       so_l, so_r, tc, ovf;

    int checks = 0;
    int errors = 0;

    // reference state: plain integers, register treated as a number modulo 16
    int m_q   = 0;
    bit m_ovf = 0;

    always #5 clk = ~clk;

    dffa_univ #(.WIDTH(4), .RST_VAL(4'b0000)) dut (
        .clk(clk), .clr_n(clr_n), .sclr(sclr), .load(load), .en(en),
        .mode(mode), .da(da), .sin_r(sin_r), .sin_l(sin_l),
        .qa(qa), .so_l(so_l), .so_r(so_r), .tc(tc), .ovf(ovf)
    );

    function automatic bit model_tc();
        return (mode == 3'd5 && m_q == 15) || (mode == 3'd6 && m_q == 0);
    endfunction

    // advance the model with the currently driven inputs, then let the DUT take the same edge
    task automatic tick();
        if (sclr) begin
            m_q = 0; m_ovf = 0;
        end else if (load) begin
            m_q = int'(da); m_ovf = 0;
        end else if (en) begin
            case (mode)
                3'd1: m_q = (m_q * 2 + int'(sin_r)) % 16;
                3'd2: m_q = int'(sin_l) * 8 + m_q / 2;
                3'd3: m_q = (m_q * 2) % 16 + m_q / 8;
                3'd4: m_q = (m_q % 2) * 8 + m_q / 2;
                3'd5: begin if (m_q == 15) m_ovf = 1; m_q = (m_q + 1) % 16; end
                3'd6: begin if (m_q == 0) m_ovf = 1; m_q = (m_q + 15) % 16; end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr_n = 0; sclr = 0; load = 0; en = 0; mode = 0; da = 0; sin_r = 0; sin_l = 0;
        #3;
        checks++; if (qa !== 4'b0000) begin errors++; $display("FAIL reset_qa_async: got %b want 0000", qa); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf_async: got %b want 0", ovf); end
        load = 1; da = 4'b1111;
        @(posedge clk); #1;
        checks++; if (qa !== 4'b0000) begin errors++; $display("FAIL reset_hold_qa: got %b want 0000", qa); end
        clr_n = 1; m_q = 0; m_ovf = 0;
        load = 1; da = 4'b1011;
        tick();
        checks++; if (qa !== 4'b1011) begin errors++; $display("FAIL load_1011: got %b want 1011", qa); end
        load = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (qa !== 4'b1011) begin errors++; $display("FAIL hold_%0d: got %b want 1011", i, qa); end
        end
    endtask

    task automatic test_shift_rotate();
        en = 1; mode = 3'b001; sin_r = 1;
        tick();
        checks++; if (qa !== 4'b0111) begin errors++; $display("FAIL shl: got %b want 0111", qa); end
        checks++; if (so_l !== 1'b0 || so_r !== 1'b1) begin errors++; $display("FAIL shl_so: got so_l=%b so_r=%b want 0 1", so_l, so_r); end
        mode = 3'b100;
        tick();
        checks++; if (qa !== 4'b1011) begin errors++; $display("FAIL ror: got %b want 1011", qa); end
        mode = 3'b010; sin_l = 0;
        tick();
        checks++; if (qa !== 4'b0101) begin errors++; $display("FAIL shr: got %b want 0101", qa); end
    endtask

    task automatic test_up_wrap();
        en = 0; load = 1; da = 4'b1110;
        tick();
        load = 0; mode = 3'b101;
        #1;
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL up_tc_1110: got %b want 0", tc); end
        en = 1;
        tick();
        checks++; if (qa !== 4'b1111 || tc !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL up_1111: got qa=%b tc=%b ovf=%b want 1111 1 0", qa, tc, ovf); end
        en = 0; #1;
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL tc_no_en: got %b want 1", tc); end
        en = 1;
        tick();
        checks++; if (qa !== 4'b0000 || tc !== 1'b0 || ovf !== 1'b1) begin errors++; $display("FAIL up_wrap: got qa=%b tc=%b ovf=%b want 0000 0 1", qa, tc, ovf); end
        tick();
        checks++; if (qa !== 4'b0001 || ovf !== 1'b1) begin errors++; $display("FAIL up_sticky: got qa=%b ovf=%b want 0001 1", qa, ovf); end
        mode = 3'b011;
        tick();
        checks++; if (qa !== 4'b0010 || ovf !== 1'b1) begin errors++; $display("FAIL rol_sticky: got qa=%b ovf=%b want 0010 1", qa, ovf); end
    endtask

    task automatic test_down_wrap();
        en = 0; load = 1; da = 4'b0001;
        tick();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL load_clears_ovf: got %b want 0", ovf); end
        load = 0; en = 1; mode = 3'b110;
        tick();
        checks++; if (qa !== 4'b0000 || tc !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL dn_0000: got qa=%b tc=%b ovf=%b want 0000 1 0", qa, tc, ovf); end
        tick();
        checks++; if (qa !== 4'b1111 || ovf !== 1'b1) begin errors++; $display("FAIL dn_wrap: got qa=%b ovf=%b want 1111 1", qa, ovf); end
        load = 1; da = 4'b0101;
        tick();
        checks++; if (qa !== 4'b0101 || ovf !== 1'b0) begin errors++; $display("FAIL dn_reload: got qa=%b ovf=%b want 0101 0", qa, ovf); end
        load = 0;
    endtask

    task automatic test_priority();
        sclr = 1; load = 1; da = 4'b1010; en = 1; mode = 3'b101;
        tick();
        checks++; if (qa !== 4'b0000) begin errors++; $display("FAIL sclr_over_load: got %b want 0000", qa); end
        sclr = 0; load = 1; da = 4'b0110;
        tick();
        checks++; if (qa !== 4'b0110) begin errors++; $display("FAIL load_over_en: got %b want 0110", qa); end
        load = 0; mode = 3'b111;
        tick();
        checks++; if (qa !== 4'b0110 || ovf !== 1'b0) begin errors++; $display("FAIL mode111: got qa=%b ovf=%b want 0110 0", qa, ovf); end
        load = 1; da = 4'b1111; mode = 3'b101;
        tick();
        tick();
        checks++; if (qa !== 4'b1111 || ovf !== 1'b0) begin errors++; $display("FAIL wrap_vs_load: got qa=%b ovf=%b want 1111 0", qa, ovf); end
        load = 0; mode = 3'b110; en = 0;
        tick();
        sclr = 1;
        tick();
        checks++; if (qa !== 4'b0000 || ovf !== 1'b0) begin errors++; $display("FAIL sclr: got qa=%b ovf=%b want 0000 0", qa, ovf); end
        sclr = 0;
    endtask

    task automatic test_async_reset();
        en = 0; load = 1; da = 4'b1111;
        tick();
        load = 0; en = 1; mode = 3'b101;
        for (int i = 0; i < 7; i++) tick();
        checks++; if (qa !== 4'b0110 || ovf !== 1'b1) begin errors++; $display("FAIL pre_arst: got qa=%b ovf=%b want 0110 1", qa, ovf); end
        #2 clr_n = 0;
        #1;
        checks++; if (qa !== 4'b0000 || ovf !== 1'b0) begin errors++; $display("FAIL arst_mid: got qa=%b ovf=%b want 0000 0", qa, ovf); end
        clr_n = 1; m_q = 0; m_ovf = 0;
        tick();
        checks++; if (qa !== 4'b0001 || ovf !== 1'b0) begin errors++; $display("FAIL arst_resume: got qa=%b ovf=%b want 0001 0", qa, ovf); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            sclr  = ($urandom_range(0, 15) == 0);
            load  = ($urandom_range(0, 7) == 0);
            en    = ($urandom_range(0, 3) != 0);
            mode  = 3'($urandom_range(0, 7));
            da    = 4'($urandom);
            sin_r = 1'($urandom);
            sin_l = 1'($urandom);
            #1;
            checks++; if (tc !== model_tc()) begin errors++; $display("FAIL rnd_tc[%0d]: got %b want %b", i, tc, model_tc()); end
            tick();
            checks++; if (qa !== 4'(m_q) || ovf !== m_ovf) begin errors++; $display("FAIL rnd_q[%0d]: got qa=%b ovf=%b want %b %b", i, qa, ovf, 4'(m_q), m_ovf); end
            checks++; if (so_l !== (m_q >= 8) || so_r !== (m_q % 2 == 1)) begin errors++; $display("FAIL rnd_so[%0d]: got %b%b want q=%0d", i, so_l, so_r, m_q); end
            if ($urandom_range(0, 40) == 0) begin
                clr_n = 0; #2;
                m_q = 0; m_ovf = 0;
                checks++; if (qa !== 4'b0000 || ovf !== 1'b0) begin errors++; $display("FAIL rnd_arst[%0d]: got qa=%b ovf=%b want 0000 0", i, qa, ovf); end
                clr_n = 1; #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_shift_rotate();
        test_up_wrap();
        test_down_wrap();
        test_priority();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dffa_univ.md
# dffa_univ

Parametrised universal register: the next generation of the team's 4-bit loadable clear-able register. It keeps parallel load and adds synchronous clear, clock enable, shift/rotate in both directions, up/down counting, a terminal-count flag and a sticky wrap flag. It serves as the general storage, shift and count element for datapath labs. It replaces ad-hoc register, shifter and counter variants with one block.

## Interface

Parameters:
- WIDTH, 4, register width in bits; legal range ≥ 2.
- RST_VAL, 0, value loaded into qa by async reset and by sclr.

Ports:
- clk, input, 1, rising-edge clock.
- clr_n, input, 1, asynchronous active-low reset.
- sclr, input, 1, synchronous clear, active-high.
- load, input, 1, synchronous parallel load of da.
- en, input, 1, enables the mode operation selected by mode.
- mode, input, 3, operation select (see Operation).
- da, input, WIDTH, parallel load data.
- sin_r, input, 1, serial bit entering the LSB on shift-left.
- sin_l, input, 1, serial bit entering the MSB on shift-right.
- qa, output, WIDTH, register contents (registered).
- so_l, output, 1, equals qa[WIDTH-1] (combinational).
- so_r, output, 1, equals qa[0] (combinational).
- tc, output, 1, terminal count (combinational from qa and mode).
- ovf, output, 1, sticky wrap flag (registered).

## Operation

- Reset is asynchronous: clr_n=0 forces qa=RST_VAL and ovf=0 immediately, independent of clk. Both hold while clr_n=0.
- Priority at each rising clk edge with clr_n=1: sclr > load > en.
  - sclr=1: qa←RST_VAL, ovf←0.
  - else load=1: qa←da, ovf←0.
  - else en=1: apply mode.
  - else: qa and ovf hold.
- Mode encoding (applies only when en=1 and no sclr/load):
  - 000 hold.
  - 001 shift left: qa←{qa[WIDTH-2:0], sin_r}.
  - 010 shift right: qa←{sin_l, qa[WIDTH-1:1]}.
  - 011 rotate left: qa←{qa[WIDTH-2:0], qa[WIDTH-1]}.
  - 100 rotate right: qa←{qa[0], qa[WIDTH-1:1]}.
  - 101 count up: qa←qa+1, modulo 2^WIDTH.
  - 110 count down: qa←qa−1, modulo 2^WIDTH.
  - 111 reserved: behaves as hold. It must not corrupt qa or ovf.
- Arithmetic is unsigned, WIDTH bits. Carry and borrow are discarded except through ovf.
- tc:
  - Mode 101: tc=1 when qa is all ones.
  - Mode 110: tc=1 when qa is zero.
  - Otherwise tc=0.
  - tc does not depend on en.
- ovf set condition: ovf←1 on any edge where a count wraps:
  - up count with qa all ones, or
  - down count with qa zero.
  - The condition is en=1 && tc=1 in a count mode with no sclr/load.
- ovf clears only on reset, sclr or load. It never self-clears, and shifts and rotates leave it unchanged.
- No internal state beyond qa and ovf.

## Timing

- All qa/ovf updates occur on the rising edge of clk. Latency from any control input to qa is one clock.
- so_l, so_r and tc follow qa/mode combinationally. They are valid the same cycle qa changes.
- Inputs are sampled at the rising edge. Changes between edges have no effect until the next edge.
- Reset mid-operation: clr_n falling between edges clears qa/ovf without waiting for clk.
- clr_n deasserting with no change in sclr, load or en: the first edge after release performs the normal priority evaluation.
- Simultaneous sclr and load: sclr wins, and da is ignored.
- Simultaneous load and en: load wins, and the mode is ignored for that edge.
- Wrap and load in the same cycle: load wins, and ovf ends at 0.
- Mode change while en=1 takes effect on the next edge. No state carries across modes.

## Test plan

WIDTH=4, RST_VAL=0.
- **Reset and load.** Hold clr_n=0, then release; at the next edge apply load=1, da=4'b1011. Required: qa=0000 and ovf=0 during reset, then qa=1011 after one edge. Drop load with en=0: qa holds 1011 for 3 edges.
- **Shift and rotate.**
  - From qa=1011, mode=001, en=1, sin_r=1: qa=0111, so_l=0.
  - Then mode=100: qa=1011.
  - Then mode=010 with sin_l=0: qa=0101.
- **Up count and wrap.** Load 1110, mode=101, en=1. Sequence must be 1111 (tc=1, ovf=0), then 0000 (tc=0, ovf=1). ovf stays 1 for further counts and through a switch to mode=011.
- **Down count and wrap.** Load 0001, mode=110. Sequence must be 0000 (tc=1), then 1111 with ovf=1. A following load of 0101 gives qa=0101, ovf=0.
- **Priority.**
  - sclr=1 with load=1, da=1010, en=1: qa=0000.
  - load=1 with en=1, mode=101: qa=da exactly, not da+1.
  - mode=111 with en=1: qa unchanged.
- **Async reset mid-count.** While counting up at qa=0110 with ovf=1, pulse clr_n low between edges. Required: qa=0000 and ovf=0 before the next edge. After release, counting resumes from 0000.
